// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: state encoding, default operand width and counter-width helper
package serial_addsub_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction
endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/done handshake and operand/result bus; optional zero flag under SERIAL_ADDSUB_ZERO_FLAG_EN
interface serial_addsub_if import serial_addsub_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic             zero;
    modport master (output start, sub, a, b, input busy, done, result, carry_out, overflow, zero);
    modport slave  (input start, sub, a, b, output busy, done, result, carry_out, overflow, zero);
`else
    modport master (output start, sub, a, b, input busy, done, result, carry_out, overflow);
    modport slave  (input start, sub, a, b, output busy, done, result, carry_out, overflow);
`endif
endinterface

// File: rtl/serial_addsub_full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder
module full_adder_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_x ^ i_y ^ i_cin;
    assign o_cout = (i_x & i_y) | (i_x & i_cin) | (i_y & i_cin);
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial adder/subtractor; optional zero flag under SERIAL_ADDSUB_ZERO_FLAG_EN
module serial_addsub import serial_addsub_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;
    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_final;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    assign w_final  = {w_sum, r_shift[WIDTH-1:1]};

    full_adder_cell u_fa (
        .i_x    (r_op_a[0]),
        .i_y    (r_op_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic: one pass of WIDTH shift cycles, then a single DONE cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    // state-decoded handshake outputs
    always_comb begin
        bus.busy = (r_state != IDLE);
        bus.done = (r_state == DONE);
    end

    // operand load (subtract = add inverted b with carry-in 1) and per-bit shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_shift <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_op_a  <= r_op_a >> 1;
            r_op_b  <= r_op_b >> 1;
            r_shift <= w_final;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // visible result and flags update only on the final bit, so they hold between operations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_last) begin
            r_result    <= w_final;
            r_carry_out <= w_cout;
            r_overflow  <= r_carry ^ w_cout;
        end
    end

    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic r_zero;

    // zero flag latched alongside the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_zero <= 1'b0;
        else if (w_last) r_zero <= (w_final == '0);
    end

    assign bus.zero = r_zero;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: table vectors, hand-written corner sequences and random ops against a scoreboard
module tb_serial_addsub;
    typedef struct packed {
        logic [7:0] res;
        logic       co;
        logic       ov;
        logic       z;
    } exp_t;

    typedef struct packed {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) bus ();

    serial_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t mk(input logic [7:0] res, input logic co, input logic ov, input logic z);
        exp_t e;
        e.res = res;
        e.co  = co;
        e.ov  = ov;
        e.z   = z;
        return e;
    endfunction

    function automatic exp_t model(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        exp_t       e;
        t     = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
        e.res = t[7:0];
        e.co  = t[8];
        e.ov  = s ? ((a[7] != b[7]) && (t[7] != a[7])) : ((a[7] == b[7]) && (t[7] != a[7]));
        e.z   = (t[7:0] == 8'h00);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic check_flags(input exp_t g);
        check("result", 32'(bus.result), 32'(g.res));
        check("carry_out", 32'(bus.carry_out), 32'(g.co));
        check("overflow", 32'(bus.overflow), 32'(g.ov));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        check("zero", 32'(bus.zero), 32'(g.z));
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_result"}, 32'(bus.result), 0);
        check({tag, "_carry"}, 32'(bus.carry_out), 0);
        check({tag, "_ovf"}, 32'(bus.overflow), 0);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        check({tag, "_zero"}, 32'(bus.zero), 0);
`endif
    endtask

    // called at a falling edge; returns at the falling edge after done drops
    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int   lat;
        int   bc;
        exp_t g;
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = a;
        bus.b     = b;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        bc  = 0;
        while (!bus.done && lat < 40) begin
            bc += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        bc += int'(bus.busy);
        check("latency", 32'(lat), 8);
        g = (q.size() > 0) ? q.pop_front() : mk(8'hxx, 1'bx, 1'bx, 1'bx);
        check_flags(g);
        check("busy_cycles", 32'(bc), 9);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 0);
        check("busy_end", 32'(bus.busy), 0);
    endtask

    initial begin
        vec_t tbl[5];
        int   nd;
        exp_t g;
        tbl[0] = {1'b0, 8'h05, 8'h03, mk(8'h08, 1'b0, 1'b0, 1'b0)};
        tbl[1] = {1'b0, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1, 1'b0)};
        tbl[2] = {1'b0, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0, 1'b1)};
        tbl[3] = {1'b1, 8'h05, 8'h07, mk(8'hFE, 1'b0, 1'b0, 1'b0)};
        tbl[4] = {1'b1, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b1, 1'b0)};
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");
        for (int i = 0; i < 5; i++) do_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].e);
        // starts during SHIFT and DONE must be ignored
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        q.push_back(mk(8'h30, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        nd = 0;
        for (int k = 0; k < 14; k++) begin
            if (bus.done) begin
                nd++;
                if (q.size() > 0) begin
                    g = q.pop_front();
                    check_flags(g);
                end
            end
            bus.start = (k == 3) || (k == 8);
            bus.a     = 8'hAA;
            bus.b     = 8'h55;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("ignored_done_count", 32'(nd), 1);
        check("ignored_result", 32'(bus.result), 32'h30);
        check("ignored_busy", 32'(bus.busy), 0);
        // asynchronous reset in the middle of an operation
        bus.start = 1'b1;
        bus.a     = 8'h33;
        bus.b     = 8'h44;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(1'b0, 8'h01, 8'h01, mk(8'h02, 1'b0, 1'b0, 1'b0));
        // back-to-back random operations
        for (int i = 0; i < 200; i++) begin
            logic       s;
            logic [7:0] a;
            logic [7:0] b;
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            do_op(s, a, b, model(s, a, b));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
